// File: rtl/aliens_march_ctrl_if.sv
// aliens_march_ctrl_if: game-side inputs and march command outputs of the alien formation controller.
interface aliens_march_ctrl_if;
  logic enable;
  logic canLeft;
  logic canRight;
  logic killingAlien;
  logic victory;
  logic defeat;
  logic [2:0] motion;
  logic marchDir;
  logic halted;
  logic [23:0] period;
  modport master (
    input  enable, canLeft, canRight, killingAlien, victory, defeat,
    output motion, marchDir, halted, period
  );
  modport slave (
    output enable, canLeft, canRight, killingAlien, victory, defeat,
    input  motion, marchDir, halted, period
  );
endinterface

// File: rtl/aliens_march_ctrl.sv
// aliens_march_ctrl: paces the alien formation, issuing LEFT/RIGHT/DOWN pulses and speeding up on each kill.
module aliens_march_ctrl #(
  parameter int TICK_PERIOD_INIT = 2000000,
  parameter int TICK_PERIOD_MIN  = 200000,
  parameter int SPEEDUP_STEP     = 50000,
  parameter int DOWN_STEPS       = 10
) (
  input logic clk,
  input logic reset,
  aliens_march_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, MARCH_R, DOWN_R, MARCH_L, DOWN_L, HALT} stateType;
  localparam logic [23:0] periodInit = 24'(TICK_PERIOD_INIT);
  localparam logic [23:0] periodMin = 24'(TICK_PERIOD_MIN);
  localparam logic [23:0] periodStep = 24'(SPEEDUP_STEP);
  localparam logic [15:0] lastDown = 16'(DOWN_STEPS - 1);
  localparam logic [2:0] cmdLeft = 3'd1;
  localparam logic [2:0] cmdRight = 3'd2;
  localparam logic [2:0] cmdDown = 3'd3;
  stateType state, stateNext;
  logic [23:0] count, countNext, period, periodNext;
  logic [15:0] downCount, downNext;
  logic [2:0] motion, motionNext;
  logic dir, dirNext, killQ, tick, killEdge;
  assign killEdge = bus.killingAlien & ~killQ & (state != HALT);
  assign tick = count >= period - 24'd1;
  always_comb begin
    stateNext = state;
    countNext = count;
    downNext = downCount;
    motionNext = 3'd0;
    // period never drops below the floor, and the subtraction cannot wrap
    periodNext = killEdge ? ((period - periodMin < periodStep) ? periodMin : period - periodStep) : period;
    if (bus.victory | bus.defeat) begin
      stateNext = HALT;
    end else if (state == IDLE) begin
      if (bus.enable) begin
        stateNext = MARCH_R;
        countNext = '0;
      end
    end else if (state != HALT && bus.enable) begin
      countNext = tick ? '0 : count + 24'd1;
      if (tick) begin
        case (state)
          MARCH_R: begin
            motionNext = bus.canRight ? cmdRight : 3'd0;
            stateNext = bus.canRight ? MARCH_R : DOWN_R;
            downNext = bus.canRight ? downCount : '0;
          end
          MARCH_L: begin
            motionNext = bus.canLeft ? cmdLeft : 3'd0;
            stateNext = bus.canLeft ? MARCH_L : DOWN_L;
            downNext = bus.canLeft ? downCount : '0;
          end
          DOWN_R: begin
            motionNext = cmdDown;
            stateNext = (downCount == lastDown) ? MARCH_L : DOWN_R;
            downNext = downCount + 16'd1;
          end
          DOWN_L: begin
            motionNext = cmdDown;
            stateNext = (downCount == lastDown) ? MARCH_R : DOWN_L;
            downNext = downCount + 16'd1;
          end
          default: ;
        endcase
      end
    end
    dirNext = (stateNext == HALT) ? dir : (stateNext == MARCH_L || stateNext == DOWN_L);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      downCount <= '0;
      motion <= 3'd0;
      period <= periodInit;
      dir <= 1'b0;
      killQ <= 1'b0;
    end else begin
      state <= stateNext;
      count <= countNext;
      downCount <= downNext;
      motion <= motionNext;
      period <= periodNext;
      dir <= dirNext;
      killQ <= bus.killingAlien;
    end
  end
  assign bus.motion = motion;
  assign bus.marchDir = dir;
  assign bus.halted = (state == HALT);
  assign bus.period = period;
endmodule

// File: tb/tb_aliens_march_ctrl.sv
// tb_aliens_march_ctrl: randomized bench comparing the march controller against a behavioural game model.
module tb_aliens_march_ctrl;
  localparam int INIT = 8;
  localparam int MIN = 2;
  localparam int STEP = 2;
  localparam int DOWNS = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int nChecks = 0;
  int nPass = 0;
  aliens_march_ctrl_if bus ();
  aliens_march_ctrl #(
    .TICK_PERIOD_INIT(INIT),
    .TICK_PERIOD_MIN(MIN),
    .SPEEDUP_STEP(STEP),
    .DOWN_STEPS(DOWNS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // model: mode 0 waiting, 1 marching sideways, 2 descending, 3 game over
  int mMode, mCnt, mPer, mDownLeft, mMotion;
  bit mLeft, mKillPrev;
  task automatic check(input string tag, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic modelReset();
    mMode = 0; mCnt = 0; mPer = INIT; mDownLeft = 0; mMotion = 0; mLeft = 0; mKillPrev = 0;
  endtask
  task automatic modelClock();
    bit kill;
    int cmd;
    kill = bus.killingAlien && !mKillPrev && mMode != 3;
    mKillPrev = bus.killingAlien;
    cmd = 0;
    if (bus.victory || bus.defeat) mMode = 3;
    else if (mMode == 0) begin
      if (bus.enable) begin mMode = 1; mCnt = 0; end
    end else if (mMode != 3 && bus.enable) begin
      if (mCnt >= mPer - 1) begin
        mCnt = 0;
        if (mMode == 1) begin
          if (mLeft ? bus.canLeft : bus.canRight) cmd = mLeft ? 1 : 2;
          else begin mMode = 2; mDownLeft = DOWNS; end
        end else begin
          cmd = 3;
          mDownLeft--;
          if (mDownLeft == 0) begin mMode = 1; mLeft = !mLeft; end
        end
      end else mCnt++;
    end
    if (kill) mPer = (mPer - STEP < MIN) ? MIN : mPer - STEP;
    mMotion = cmd;
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset) modelReset(); else modelClock();
      #1;
      check("motion", int'(bus.motion), mMotion);
      check("marchDir", int'(bus.marchDir), int'(mLeft));
      check("halted", int'(bus.halted), int'(mMode == 3));
      check("period", int'(bus.period), mPer);
    end
  endtask
  task automatic randomRun(input int n, input bit allowPause);
    for (int i = 0; i < n; i++) begin
      bus.enable = allowPause ? ($urandom_range(0, 9) != 0) : 1'b1;
      if ($urandom_range(0, 15) == 0) bus.canRight = ~bus.canRight;
      if ($urandom_range(0, 15) == 0) bus.canLeft = ~bus.canLeft;
      if ($urandom_range(0, 5) == 0) bus.killingAlien = ~bus.killingAlien;
      step(1);
    end
  endtask
  initial begin
    bus.enable = 0; bus.canLeft = 1; bus.canRight = 1;
    bus.killingAlien = 0; bus.victory = 0; bus.defeat = 0;
    modelReset();
    step(3);
    reset = 1;
    step(2);
    bus.enable = 1;
    step(40);
    bus.canRight = 0;
    step(60);
    bus.canLeft = 0;
    step(40);
    bus.canLeft = 1; bus.canRight = 1;
    for (int k = 0; k < 4; k++) begin
      bus.killingAlien = 1;
      step(5);
      bus.killingAlien = 0;
      step(3);
    end
    check("periodFloor", int'(bus.period), MIN);
    step(5);
    bus.enable = 0;
    step(20);
    bus.enable = 1;
    step(10);
    reset = 0;
    step(1);
    reset = 1;
    randomRun(300, 1);
    bus.enable = 1; bus.canRight = 0; bus.canLeft = 1;
    for (int i = 0; i < 200 && !(mMode == 2 && mLeft); i++) step(1);
    check("reachedDownL", int'(mMode == 2 && mLeft), 1);
    #3 reset = 0;
    #1;
    check("rstMotion", int'(bus.motion), 0);
    check("rstDir", int'(bus.marchDir), 0);
    check("rstHalted", int'(bus.halted), 0);
    check("rstPeriod", int'(bus.period), INIT);
    step(2);
    reset = 1;
    bus.canRight = 1; bus.killingAlien = 0;
    step(30);
    randomRun(40, 0);
    bus.defeat = 1;
    step(1);
    bus.defeat = 0;
    randomRun(100, 1);
    check("haltedStays", int'(bus.halted), 1);
    reset = 0;
    step(1);
    reset = 1;
    bus.enable = 1;
    randomRun(60, 1);
    bus.victory = 1;
    step(1);
    bus.victory = 0;
    randomRun(30, 1);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/aliens_march_ctrl.md
ALIENS_MARCH_CTRL -- requirements
Module: aliens_march_ctrl

Interface
REQ-001 SHALL have parameter TICK_PERIOD_INIT, default 2000000, initial clocks between motion commands.
REQ-002 SHALL have parameter TICK_PERIOD_MIN, default 200000, floor for the tick period.
REQ-003 SHALL have parameter SPEEDUP_STEP, default 50000, period decrement per alien kill.
REQ-004 SHALL have parameter DOWN_STEPS, default 10, DOWN commands issued per edge reversal.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, 1 = march runs, 0 = pause.
REQ-008 SHALL have port canLeft, input, 1, formation may step left.
REQ-009 SHALL have port canRight, input, 1, formation may step right.
REQ-010 SHALL have port killingAlien, input, 1, level; high while a laser hit is reported.
REQ-011 SHALL have port victory, input, 1, all aliens dead.
REQ-012 SHALL have port defeat, input, 1, formation reached the bottom limit.
REQ-013 SHALL have port motion, output, 3, command: 0 none, 1 LEFT, 2 RIGHT, 3 DOWN.
REQ-014 SHALL have port marchDir, output, 1, 0 = marching right, 1 = marching left.
REQ-015 SHALL have port halted, output, 1, 1 once the game has ended.
REQ-016 SHALL have port period, output, 24, current tick period in clocks.

Function
REQ-017 SHALL hold a registered FSM with states IDLE, MARCH_R, DOWN_R, MARCH_L, DOWN_L, HALT.
REQ-018 SHALL keep a 24-bit tick counter; a tick is the cycle where counter >= period-1, after which the counter returns to 0; otherwise counter increments.
REQ-019 SHALL use >= in the tick compare, so a period shrinking below the counter yields a tick on the next cycle.
REQ-020 SHALL drive motion as a one-cycle registered pulse, on the cycle after a tick only; 0 at all other times.
REQ-021 SHALL move IDLE -> MARCH_R on the first cycle enable=1, with counter cleared.
REQ-022 SHALL, on a tick in MARCH_R: canRight=1 -> pulse RIGHT; canRight=0 -> no pulse, go to DOWN_R, down counter = 0.
REQ-023 SHALL, on a tick in DOWN_R: pulse DOWN; if down counter = DOWN_STEPS-1 go to MARCH_L, else increment down counter.
REQ-024 SHALL mirror REQ-022/023 for MARCH_L (canLeft, LEFT) and DOWN_L (returning to MARCH_R).
REQ-025 SHALL set marchDir to 0 in IDLE, MARCH_R, DOWN_R and to 1 in MARCH_L, DOWN_L; hold in HALT.
REQ-026 SHALL, while enable=0 in non-HALT states: freeze counter, FSM, down counter; motion = 0.
REQ-027 SHALL detect killingAlien rising edges with a registered copy; each edge: period <= max(period - SPEEDUP_STEP, TICK_PERIOD_MIN), no underflow.
REQ-028 SHALL, on a tick coinciding with a kill edge, evaluate the tick against the old period.
REQ-029 SHALL enter HALT from any state on the cycle after victory=1 or defeat=1 is sampled, regardless of enable.
REQ-030 SHALL give HALT priority over a coincident tick: no motion pulse is emitted.
REQ-031 SHALL, in HALT, hold halted = 1, motion = 0, and stay there until reset.
REQ-032 SHALL ignore kill edges in HALT; period is frozen.

Reset
REQ-033 SHALL, when reset=0, immediately force: state IDLE, motion 0, marchDir 0, halted 0, period TICK_PERIOD_INIT, counter 0, down counter 0, kill-edge register 0.
REQ-034 SHALL abandon any in-progress march or DOWN sequence on reset, with no pulse after reset assertion.

Verification
REQ-035 SHALL use bench parameters INIT=8, MIN=2, STEP=2, DOWN_STEPS=3 for all scenarios below.
REQ-036 Release reset, enable=1, canRight=1 -> motion=2 one-cycle pulses every 8 cycles, first after 8 ticks-counted cycles; marchDir=0.
REQ-037 Drop canRight=0 before a tick -> that tick no pulse; next 3 ticks motion=3; marchDir=1 after the 3rd; then motion=1 pulses.
REQ-038 Four killingAlien edges, each held 5 cycles -> period 8,6,4,2,2; a held level counts once.
REQ-039 Assert defeat mid-MARCH_R on a tick cycle -> no pulse; halted=1 the next cycle; motion stays 0 for 100 cycles despite enable and kills.
REQ-040 enable=0 for 20 cycles at counter=5 -> no pulses; after enable=1 the next tick comes 3 cycles later.
REQ-041 Assert reset mid-DOWN_L between clock edges -> outputs reach reset values before the next edge; after release, behaviour matches REQ-036.
